// File: rtl/mem_pkg.sv
// Shared definitions for the unified memory-port arbiter.
//   REG_BUS     : core register / memory data width
//   SZ_*        : ls_size encodings (byte, half, word, double)
//   arb_state_e : arbiter FSM states
//   size_lanes  : byte-lane mask for an access size, unshifted
package mem_pkg;

  localparam int REG_BUS = 64;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_LS = 2'd2,
    ST_ERR     = 2'd3
  } arb_state_e;

  function automatic logic [7:0] size_lanes(input logic [1:0] size);
    logic [7:0] lanes;
    case (size)
      SZ_B:    lanes = 8'h01;
      SZ_H:    lanes = 8'h03;
      SZ_W:    lanes = 8'h0F;
      default: lanes = 8'hFF;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_arbiter_ls_align.sv
// Load/store data alignment, purely combinational.
//   off, size, zext : byte offset within the 8-byte word, access size, zero-extend
//   wdata           : right-aligned store data
//   wmask, wdata_sh : byte-lane write mask and lane-shifted store data
//   rdata           : raw 64-bit memory word
//   rdata_ext       : load data shifted down, truncated and sign/zero-extended
//   misaligned      : address not a multiple of the access size
module ls_align
  import mem_pkg::*;
(
  input  logic [2:0]         off,
  input  logic [1:0]         size,
  input  logic               zext,
  input  logic [REG_BUS-1:0] wdata,
  output logic [7:0]         wmask,
  output logic [REG_BUS-1:0] wdata_sh,
  input  logic [REG_BUS-1:0] rdata,
  output logic [REG_BUS-1:0] rdata_ext,
  output logic               misaligned
);

  logic [REG_BUS-1:0] rshift;

  always_comb begin
    wmask      = size_lanes(size) << off;
    wdata_sh   = wdata << {off, 3'b000};
    rshift     = rdata >> {off, 3'b000};
    rdata_ext  = rshift;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        rdata_ext = {{(REG_BUS-8){~zext & rshift[7]}}, rshift[7:0]};
      end
      SZ_H: begin
        rdata_ext  = {{(REG_BUS-16){~zext & rshift[15]}}, rshift[15:0]};
        misaligned = off[0];
      end
      SZ_W: begin
        rdata_ext  = {{(REG_BUS-32){~zext & rshift[31]}}, rshift[31:0]};
        misaligned = |off[1:0];
      end
      default: begin
        // doubles pass through unextended
        misaligned = |off;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch (IF) and the
// memory-stage load/store unit (LS). LS has priority, but fetch wins after
// FETCH_MAX_WAIT consecutive LS grants while it waits. One transaction is
// outstanding at a time.
//   clk, rst                       : clock, synchronous active-low reset
//   if_req/if_addr/if_gnt          : fetch request and grant
//   if_rvalid/if_rdata             : fetch response (32-bit instruction)
//   ls_req/we/addr/size/zext/wdata : load/store request
//   ls_gnt/ls_rvalid/ls_rdata/ls_err : load/store grant and completion
//   mem_req/we/addr/wdata/wmask    : memory command, mem_gnt accepts it
//   mem_rvalid/mem_rdata           : memory response
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | arbitrate, drive command from the winner
// ST_BUSY_IF | fetch outstanding, route mem response to IF
// ST_BUSY_LS | load/store outstanding, route mem response to LS
// ST_ERR     | misaligned LS rejected, pulse ls_rvalid with ls_err
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int FETCH_MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [REG_BUS-1:0] if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [31:0]        if_rdata,
  input  logic               ls_req,
  input  logic               ls_we,
  input  logic [REG_BUS-1:0] ls_addr,
  input  logic [1:0]         ls_size,
  input  logic               ls_zext,
  input  logic [REG_BUS-1:0] ls_wdata,
  output logic               ls_gnt,
  output logic               ls_rvalid,
  output logic [REG_BUS-1:0] ls_rdata,
  output logic               ls_err,
  output logic               mem_req,
  output logic               mem_we,
  output logic [REG_BUS-1:0] mem_addr,
  output logic [REG_BUS-1:0] mem_wdata,
  output logic [7:0]         mem_wmask,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [REG_BUS-1:0] mem_rdata
);

  localparam int WCW = $clog2(FETCH_MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(FETCH_MAX_WAIT);

  arb_state_e     state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]     off_q, off_d;
  logic [1:0]     size_q, size_d;
  logic           zext_q, zext_d;
  logic           we_q, we_d;
  logic           if_a2_q, if_a2_d;

  logic ls_win, ls_take, if_take;

  logic [2:0]         al_off;
  logic [1:0]         al_size;
  logic               al_zext;
  logic [7:0]         al_wmask;
  logic [REG_BUS-1:0] al_wdata;
  logic [REG_BUS-1:0] al_rdata;
  logic               al_mis;

  logic unused_if_lo;
  assign unused_if_lo = ^if_addr[1:0];

  // The single aligner sees the live request while arbitrating and the
  // captured attributes while a load is outstanding.
  assign al_off  = (state_q == ST_IDLE) ? ls_addr[2:0] : off_q;
  assign al_size = (state_q == ST_IDLE) ? ls_size      : size_q;
  assign al_zext = (state_q == ST_IDLE) ? ls_zext      : zext_q;

  ls_align u_ls_align (
    .off        (al_off),
    .size       (al_size),
    .zext       (al_zext),
    .wdata      (ls_wdata),
    .wmask      (al_wmask),
    .wdata_sh   (al_wdata),
    .rdata      (mem_rdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_mis)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    off_d      = off_q;
    size_d     = size_q;
    zext_d     = zext_q;
    we_d       = we_q;
    if_a2_d    = if_a2_q;
    ls_win     = 1'b0;
    ls_take    = 1'b0;
    if_take    = 1'b0;
    if_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    ls_gnt     = 1'b0;
    ls_rvalid  = 1'b0;
    ls_rdata   = '0;
    ls_err     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;

    // Outputs are held at zero for the whole reset cycle, including a
    // response that lands while reset is asserted.
    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          ls_win = ls_req && (!if_req || (wait_cnt_q < WAIT_MAX));
          if (ls_win) begin
            if (al_mis) begin
              // rejected without touching memory
              ls_take = 1'b1;
              state_d = ST_ERR;
            end else begin
              mem_req   = 1'b1;
              mem_we    = ls_we;
              mem_addr  = {ls_addr[REG_BUS-1:3], 3'b000};
              mem_wdata = ls_we ? al_wdata : '0;
              mem_wmask = ls_we ? al_wmask : 8'h00;
              ls_take   = mem_gnt;
              if (mem_gnt) state_d = ST_BUSY_LS;
            end
            if (ls_take) begin
              off_d  = ls_addr[2:0];
              size_d = ls_size;
              zext_d = ls_zext;
              we_d   = ls_we;
            end
          end else if (if_req) begin
            mem_req  = 1'b1;
            mem_addr = {if_addr[REG_BUS-1:3], 3'b000};
            if_take  = mem_gnt;
            if (mem_gnt) begin
              state_d = ST_BUSY_IF;
              if_a2_d = if_addr[2];
            end
          end
          ls_gnt = ls_take;
          if_gnt = if_take;
        end
        ST_BUSY_IF: begin
          if (mem_rvalid) begin
            if_rvalid = 1'b1;
            if_rdata  = if_a2_q ? mem_rdata[63:32] : mem_rdata[31:0];
            state_d   = ST_IDLE;
          end
        end
        ST_BUSY_LS: begin
          if (mem_rvalid) begin
            ls_rvalid = 1'b1;
            ls_rdata  = we_q ? '0 : al_rdata;
            state_d   = ST_IDLE;
          end
        end
        default: begin
          ls_rvalid = 1'b1;
          ls_err    = 1'b1;
          state_d   = ST_IDLE;
        end
      endcase

      if (!if_req || if_take) begin
        wait_cnt_d = '0;
      end else if (ls_take && (wait_cnt_q != WAIT_MAX)) begin
        wait_cnt_d = wait_cnt_q + WCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      off_q      <= '0;
      size_q     <= SZ_B;
      zext_q     <= 1'b0;
      we_q       <= 1'b0;
      if_a2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      off_q      <= off_d;
      size_q     <= size_d;
      zext_q     <= zext_d;
      we_q       <= we_d;
      if_a2_q    <= if_a2_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we, ls_zext;
  logic [63:0] ls_addr, ls_wdata;
  logic [1:0]  ls_size;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [63:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;

  mem_arbiter #(.FETCH_MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_zext(ls_zext), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t ls_q[$];
  exp_t if_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    #2;
    if (ls_rvalid) begin
      if (ls_q.size() == 0) begin
        check("unexpected ls_rvalid", 64'(ls_rvalid), 64'd0);
      end else begin
        exp_t e;
        e = ls_q.pop_front();
        check("ls_rdata", ls_rdata, e.data);
        check("ls_err", 64'(ls_err), 64'(e.err));
        check("ls_resp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (if_rvalid) begin
      if (if_q.size() == 0) begin
        check("unexpected if_rvalid", 64'(if_rvalid), 64'd0);
      end else begin
        exp_t e;
        e = if_q.pop_front();
        check("if_rdata", {32'd0, if_rdata}, e.data);
        check("if_resp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Protocol watch: a request must stay high until it is granted.
  logic if_pend = 1'b0;
  logic ls_pend = 1'b0;
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      if_pend = 1'b0;
      ls_pend = 1'b0;
    end else begin
      if (if_pend) check("protocol if_req held until gnt", 64'(if_req), 64'd1);
      if (ls_pend) check("protocol ls_req held until gnt", 64'(ls_req), 64'd1);
      if_pend = if_req && !if_gnt;
      ls_pend = ls_req && !ls_gnt;
    end
  end

  task automatic clear_inputs();
    if_req = 0; if_addr = '0;
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_size = 2'd0; ls_zext = 0; ls_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic ls_txn(input string nm, input logic [63:0] addr, input logic [1:0] size,
                        input logic we, input logic zext, input logic [63:0] wdata,
                        input logic [63:0] mrdata, input logic [63:0] exp_data,
                        input logic exp_err, input logic [7:0] exp_mask,
                        input logic [63:0] exp_mwdata);
    exp_t e;
    @(negedge clk);
    mem_rvalid = 0; mem_rdata = '0;
    ls_req = 1; ls_we = we; ls_addr = addr; ls_size = size; ls_zext = zext; ls_wdata = wdata;
    mem_gnt = !exp_err;
    #1;
    check({nm, " ls_gnt"}, 64'(ls_gnt), 64'd1);
    check({nm, " mem_req"}, 64'(mem_req), 64'(!exp_err));
    if (!exp_err) begin
      check({nm, " mem_addr"}, mem_addr, {addr[63:3], 3'b000});
      check({nm, " mem_we"}, 64'(mem_we), 64'(we));
      if (we) begin
        check({nm, " mem_wmask"}, 64'(mem_wmask), 64'(exp_mask));
        check({nm, " mem_wdata"}, mem_wdata, exp_mwdata);
      end
    end
    e.data = exp_data; e.err = exp_err; e.cyc = cyc + 1;
    ls_q.push_back(e);
    @(negedge clk);
    ls_req = 0; ls_we = 0; mem_gnt = 0;
    if (!exp_err) begin
      mem_rvalid = 1; mem_rdata = mrdata;
    end
    #1;
    check({nm, " no command while busy"}, {61'd0, ls_gnt, if_gnt, mem_req}, 64'd0);
  endtask

  task automatic if_txn(input string nm, input logic [63:0] addr, input logic [63:0] mrdata,
                        input logic [31:0] exp_data, input logic [63:0] exp_maddr);
    exp_t e;
    @(negedge clk);
    mem_rvalid = 0; mem_rdata = '0;
    if_req = 1; if_addr = addr; mem_gnt = 1;
    #1;
    check({nm, " if_gnt"}, 64'(if_gnt), 64'd1);
    check({nm, " mem_req"}, 64'(mem_req), 64'd1);
    check({nm, " mem_addr"}, mem_addr, exp_maddr);
    check({nm, " mem_we"}, 64'(mem_we), 64'd0);
    e.data = {32'd0, exp_data}; e.err = 0; e.cyc = cyc + 1;
    if_q.push_back(e);
    @(negedge clk);
    if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = mrdata;
  endtask

  logic pat_ls [0:6];

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    pat_ls = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    clear_inputs();
    rst = 0;
    ls_req = 1; if_req = 1; ls_size = 2'd3; mem_gnt = 1;
    repeat (2) @(negedge clk);
    #1;
    check("reset outputs", {53'd0, mem_req, mem_we, if_gnt, ls_gnt, if_rvalid, ls_rvalid, ls_err, mem_wmask != 8'd0, mem_addr != 64'd0, mem_wdata != 64'd0}, 64'd0);
    @(negedge clk);
    clear_inputs();
    rst = 1;
    #1;
    check("idle outputs", {53'd0, mem_req, mem_we, if_gnt, ls_gnt, if_rvalid, ls_rvalid, ls_err, mem_wmask != 8'd0, mem_addr != 64'd0, ls_rdata != 64'd0}, 64'd0);

    // fetch
    if_txn("fetch hi", 64'h1004, 64'hAAAA_BBBB_CCCC_DDDD, 32'hAAAA_BBBB, 64'h1000);
    if_txn("fetch lo", 64'h100B, 64'h1111_2222_3333_4444, 32'h3333_4444, 64'h1008);

    // loads
    ls_txn("lb",  64'h2003, 2'd0, 0, 0, '0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 0, 8'h00, '0);
    ls_txn("lbu", 64'h2003, 2'd0, 0, 1, '0, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, 0, 8'h00, '0);
    ls_txn("lh",  64'h2002, 2'd1, 0, 0, '0, 64'h1111_2222_8001_3333, 64'hFFFF_FFFF_FFFF_8001, 0, 8'h00, '0);
    ls_txn("lhu", 64'h2006, 2'd1, 0, 1, '0, 64'h9ABC_0000_0000_0000, 64'h0000_0000_0000_9ABC, 0, 8'h00, '0);
    ls_txn("lw",  64'h2004, 2'd2, 0, 0, '0, 64'hF000_0001_0000_0000, 64'hFFFF_FFFF_F000_0001, 0, 8'h00, '0);
    ls_txn("lwu", 64'h2004, 2'd2, 0, 1, '0, 64'hF000_0001_0000_0000, 64'h0000_0000_F000_0001, 0, 8'h00, '0);
    ls_txn("ld",  64'h2008, 2'd3, 0, 0, '0, 64'h8877_6655_4433_2211, 64'h8877_6655_4433_2211, 0, 8'h00, '0);

    // stores
    ls_txn("sh", 64'h2006, 2'd1, 1, 0, 64'h1234, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 0, 8'hC0, 64'h1234_0000_0000_0000);
    ls_txn("sw", 64'h200C, 2'd2, 1, 0, 64'hDEAD_BEEF, 64'h5555_5555_5555_5555, 64'd0, 0, 8'hF0, 64'hDEAD_BEEF_0000_0000);
    ls_txn("sb", 64'h2001, 2'd0, 1, 0, 64'hA5, 64'h0, 64'd0, 0, 8'h02, 64'h0000_0000_0000_A500);
    ls_txn("sd", 64'h2010, 2'd3, 1, 0, 64'h0102_0304_0506_0708, 64'h0, 64'd0, 0, 8'hFF, 64'h0102_0304_0506_0708);

    // misaligned
    ls_txn("lw misaligned", 64'h2002, 2'd2, 0, 0, '0, '0, 64'd0, 1, 8'h00, '0);
    ls_txn("lh misaligned", 64'h2001, 2'd1, 0, 0, '0, '0, 64'd0, 1, 8'h00, '0);
    ls_txn("sd misaligned", 64'h2004, 2'd3, 1, 0, 64'h77, '0, 64'd0, 1, 8'h00, '0);

    // command held stable while memory stalls
    @(negedge clk);
    mem_rvalid = 0; mem_rdata = '0;
    ls_req = 1; ls_we = 0; ls_addr = 64'h5008; ls_size = 2'd3; ls_zext = 0; mem_gnt = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("stall mem_req", 64'(mem_req), 64'd1);
      check("stall mem_addr", mem_addr, 64'h5008);
      check("stall ls_gnt", 64'(ls_gnt), 64'd0);
      @(negedge clk);
    end
    mem_gnt = 1;
    #1;
    check("stall release ls_gnt", 64'(ls_gnt), 64'd1);
    begin
      exp_t e;
      e.data = 64'hCAFE_F00D_1234_5678; e.err = 0; e.cyc = cyc + 1;
      ls_q.push_back(e);
    end
    @(negedge clk);
    ls_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'hCAFE_F00D_1234_5678;

    // starvation bound: LS,LS,LS,LS,IF,LS then IF once LS drops
    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      mem_rvalid = 0; mem_rdata = '0;
      ls_req = (s < 6); if_req = 1; ls_we = 0; ls_size = 2'd3; ls_zext = 0;
      ls_addr = 64'h3000; if_addr = 64'h4000; mem_gnt = 1;
      #1;
      check($sformatf("starve ls_gnt #%0d", s), 64'(ls_gnt), 64'(pat_ls[s]));
      check($sformatf("starve if_gnt #%0d", s), 64'(if_gnt), 64'(!pat_ls[s]));
      begin
        exp_t e;
        e.err = 0; e.cyc = cyc + 1;
        if (pat_ls[s]) begin
          e.data = 64'h0123_4567_89AB_CDEF;
          ls_q.push_back(e);
        end else begin
          e.data = 64'h0000_0000_89AB_CDEF;
          if_q.push_back(e);
        end
      end
      @(negedge clk);
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
      ls_req = (s < 5); if_req = (s < 6);
    end

    // reset in the middle of an outstanding load
    @(negedge clk);
    mem_rvalid = 0; mem_rdata = '0;
    ls_req = 1; ls_we = 0; ls_addr = 64'h6000; ls_size = 2'd3; mem_gnt = 1;
    #1;
    check("rst-mid ls_gnt", 64'(ls_gnt), 64'd1);
    @(negedge clk);
    ls_req = 0; mem_gnt = 0; rst = 0; mem_rvalid = 1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    #1;
    check("rst-mid outputs in reset", {57'd0, ls_rvalid, if_rvalid, ls_err, mem_req, ls_gnt, if_gnt, ls_rdata != 64'd0}, 64'd0);
    @(negedge clk);
    rst = 1;
    #1;
    check("rst-mid late rvalid ignored", {59'd0, ls_rvalid, if_rvalid, ls_err, mem_req, ls_rdata != 64'd0}, 64'd0);
    if_txn("fetch after reset", 64'h7004, 64'h0BAD_F00D_0000_0001, 32'h0BAD_F00D, 64'h7000);

    @(negedge clk);
    clear_inputs();
    repeat (2) @(negedge clk);
    #3;
    check("ls scoreboard drained", 64'(ls_q.size()), 64'd0);
    check("if scoreboard drained", 64'(if_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single unified memory port between instruction fetch (IF) and the load/store access of the memory stage (LS). It arbitrates between the two, with LS taking priority and a bounded-wait guarantee for fetch. It keeps one transaction outstanding, generates byte-lane write masks, and aligns and sign- or zero-extends load data. It sits between the IF/MEM stages and the memory interface.

## Interface
- `FETCH_MAX_WAIT`, default 4: number of consecutive LS grants allowed while `if_req` is pending before fetch is forced to win.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `if_req` in 1: fetch request; held high until `if_gnt`.
- `if_addr` in 64: fetch address; bits [1:0] are ignored.
- `if_gnt` out 1: request accepted by memory this cycle.
- `if_rvalid` out 1: fetch data valid, one-cycle pulse.
- `if_rdata` out 32: instruction word selected by `if_addr[2]` as captured at grant.
- `ls_req` in 1: load/store request; held high until `ls_gnt`.
- `ls_we` in 1: 1 = store.
- `ls_addr` in 64: byte address.
- `ls_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = double.
- `ls_zext` in 1: zero-extend load data (lbu/lhu/lwu).
- `ls_wdata` in 64: store data, right-aligned.
- `ls_gnt` out 1: accepted.
- `ls_rvalid` out 1: completion pulse; also pulses for stores.
- `ls_rdata` out 64: aligned, extended load data; 0 for stores.
- `ls_err` out 1: misaligned access; valid with `ls_rvalid`.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 64 (8-byte aligned), `mem_wdata` out 64 (lane-shifted), `mem_wmask` out 8: memory command.
- `mem_gnt` in 1: memory accepts the command this cycle.
- `mem_rvalid` in 1, `mem_rdata` in 64: response, at least 1 cycle after `mem_gnt`.

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_LS, ERR.
- Arbitration in IDLE is combinational.
  - Winner = LS if `ls_req` and (not `if_req` or `wait_cnt` < `FETCH_MAX_WAIT`); otherwise IF if `if_req`.
  - `mem_req` and the command fields are driven from the winner.
  - The winner's gnt = `mem_gnt`.
- Misaligned LS: `ls_addr` mod (1<<`ls_size`) != 0.
  - If LS wins, no `mem_req`; `ls_gnt`=1 immediately.
  - Next state ERR; in ERR, `ls_rvalid`=1 and `ls_err`=1, then IDLE.
- Transitions:
  - IDLE→BUSY_IF/BUSY_LS on `mem_gnt`.
  - BUSY_x→IDLE on `mem_rvalid`.
  - ERR→IDLE unconditionally.
- Captured at grant: `ls_addr[2:0]`, `ls_size`, `ls_zext`, `ls_we`, `if_addr[2]`.
- Write mask = ((1<<(1<<size))−1) << `addr[2:0]`. `mem_wdata` = `ls_wdata` << (8·`addr[2:0]`).
- Load data = `mem_rdata` >> (8·off), truncated to size, then sign- or zero-extended to 64 bits. Doubles are never extended.
- Response routing in BUSY_x: `x_rvalid` = `mem_rvalid`, with data combinational from `mem_rdata`.
- `wait_cnt` (width clog2(`FETCH_MAX_WAIT`+1)):
  - +1 on each LS grant (including misaligned) while `if_req`=1, saturating.
  - Cleared on IF grant or when `if_req`=0.
- No new command is issued in BUSY or ERR; all gnt outputs are 0 there.
- Reset (`rst`=0 at an edge): state IDLE, `wait_cnt`=0. A `mem_rvalid` arriving after reset in IDLE is ignored; the memory is reset together with the core.

## Timing
- All outputs are 0 while in reset or in IDLE with no request.
- Minimum transaction: grant in cycle N, `rvalid` in cycle N+1, IDLE in N+2, next grant in N+2. That is one bubble between back-to-back accesses.
- Misaligned LS: gnt in N, `ls_rvalid`/`ls_err` in N+1, next grant in N+2.
- When both `ls_req` and `if_req` are high, LS wins the first `FETCH_MAX_WAIT` times; the next arbitration goes to IF.
- A requester whose `req` drops before `gnt` is a protocol violation; the bench flags it and the RTL does not check it.
- If `mem_gnt` is low, `mem_req` and its fields stay stable while the requests are held.

## Structure
- Shared package `mem_pkg`:
  - size encodings `SZ_B`/`SZ_H`/`SZ_W`/`SZ_D`
  - FSM state enum
  - `REG_BUS` width constant, taken from the existing defines
- One sub-module `ls_align`, purely combinational: write-mask and wdata shift; load shift and extend; misalign detect. It is instantiated once and reused for both paths.

## Test plan
- Fetch only: `if_addr`=0x1004, `mem_rdata`=0xAAAA_BBBB_CCCC_DDDD with 1-cycle latency. Expect `if_gnt` in N, `if_rvalid` in N+1, `if_rdata`=0xAAAABBBB, `mem_addr`=0x1000.
- Load: lb at 0x2003 with byte 0x80 → `ls_rdata`=0xFFFF_FFFF_FFFF_FF80. The same access as lbu → 0x80.
- Store: sh at 0x2006, `ls_wdata`=0x1234 → `mem_wmask`=0xC0, `mem_wdata`=0x1234_0000_0000_0000, then `ls_rvalid` pulse with `ls_rdata`=0.
- Misaligned: lw at 0x2002 → no `mem_req`; `ls_gnt` in N, `ls_rvalid`=`ls_err`=1 in N+1.
- Starvation bound: `if_req` and `ls_req` held continuously with `FETCH_MAX_WAIT`=4 → grants LS,LS,LS,LS,IF,LS…
- Reset mid-transaction: `rst`=0 in BUSY_LS, then a `mem_rvalid` arrives → state IDLE, no `ls_rvalid`, all outputs 0.
